// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode map, default widths and instruction field positions
package cpu_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 5;
  localparam int DEF_IW = 8;

  // Opcode occupies the top three instruction bits; operand the low AW bits
  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational accumulator ALU
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  opcode_e       opcode,
  input  logic [DW-1:0] acc,
  input  logic [DW-1:0] da_rdata,
  output logic [DW-1:0] result
);

  // Arithmetic/logic result; non-ALU opcodes pass the accumulator through
  always_comb begin
    result = acc;
    case (opcode)
      OP_ADD:  result = acc + da_rdata;
      OP_AND:  result = acc & da_rdata;
      OP_XOR:  result = acc ^ da_rdata;
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/cpu_datapath.sv
// rtl/cpu_datapath.sv - CPU datapath: pc, ir, accumulator, zero flag, halt latch
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int IW = DEF_IW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pc_load,
  input  logic          pc_en,
  input  logic          halt,
  input  logic          accumulator_load,
  input  logic          accumulator_control,
  input  logic          memIns_en,
  input  logic          memDa_en,
  input  logic          memDa_we,
  output logic [2:0]    opcode,
  output logic [AW-1:0] ins_addr,
  input  logic [IW-1:0] ins_rdata,
  output logic [AW-1:0] da_addr,
  output logic          da_en,
  output logic          da_we,
  output logic [DW-1:0] da_wdata,
  input  logic [DW-1:0] da_rdata,
  output logic [DW-1:0] acc,
  output logic          zero,
  output logic          halted
);

  logic [AW-1:0] pc;
  logic [IW-1:0] ir;
  logic          ins_en_q;
  opcode_e       op;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] acc_next;
  logic [AW-1:0] pc_next;
  logic          fetch_edge;

  assign op         = opcode_e'(ir[IW-1 -: OP_W]);
  assign opcode     = ir[IW-1 -: OP_W];
  assign ins_addr   = pc;
  assign da_addr    = ir[AW-1:0];
  assign da_en      = memDa_en;
  assign da_we      = memDa_we & ~halted;
  assign da_wdata   = acc;
  // IR loads only on the rising edge of the fetch enable, never on a held level
  assign fetch_edge = memIns_en & ~ins_en_q;

  cpu_alu #(.DW(DW)) u_alu (
    .opcode   (op),
    .acc      (acc),
    .da_rdata (da_rdata),
    .result   (alu_result)
  );

  // Accumulator source: memory load or ALU result
  always_comb begin
    acc_next = accumulator_control ? da_rdata : alu_result;
  end

  // PC next value: JMP beats SKZ beats plain advance; all arithmetic wraps
  always_comb begin
    pc_next = pc;
    if (pc_load && op == OP_JMP) begin
      pc_next = ir[AW-1:0];
    end else if (pc_load && op == OP_SKZ) begin
      pc_next = pc + (zero ? AW'(2) : AW'(1));
    end else if (pc_en) begin
      pc_next = pc + AW'(1);
    end
  end

  // Architectural registers; halted freezes pc/ir/acc from the cycle after halt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= '0;
      ir       <= '0;
      acc      <= '0;
      zero     <= 1'b1;
      halted   <= 1'b0;
      ins_en_q <= 1'b0;
    end else begin
      ins_en_q <= memIns_en;
      if (halt) begin
        halted <= 1'b1;
      end
      if (!halted) begin
        pc <= pc_next;
        if (fetch_edge) begin
          ir <= ins_rdata;
        end
        if (accumulator_load) begin
          acc  <= acc_next;
          zero <= (acc_next == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// tb/tb_cpu_datapath.sv - directed self-checking bench for cpu_datapath
module tb_cpu_datapath;

  logic       clk;
  logic       rst;
  logic       pc_load;
  logic       pc_en;
  logic       halt;
  logic       accumulator_load;
  logic       accumulator_control;
  logic       memIns_en;
  logic       memDa_en;
  logic       memDa_we;
  logic [2:0] opcode;
  logic [4:0] ins_addr;
  logic [7:0] ins_rdata;
  logic [4:0] da_addr;
  logic       da_en;
  logic       da_we;
  logic [7:0] da_wdata;
  logic [7:0] da_rdata;
  logic [7:0] acc;
  logic       zero;
  logic       halted;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_datapath dut (
    .clk                 (clk),
    .rst                 (rst),
    .pc_load             (pc_load),
    .pc_en               (pc_en),
    .halt                (halt),
    .accumulator_load    (accumulator_load),
    .accumulator_control (accumulator_control),
    .memIns_en           (memIns_en),
    .memDa_en            (memDa_en),
    .memDa_we            (memDa_we),
    .opcode              (opcode),
    .ins_addr            (ins_addr),
    .ins_rdata           (ins_rdata),
    .da_addr             (da_addr),
    .da_en               (da_en),
    .da_we               (da_we),
    .da_wdata            (da_wdata),
    .da_rdata            (da_rdata),
    .acc                 (acc),
    .zero                (zero),
    .halted              (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pc_load             = 1'b0;
    pc_en               = 1'b0;
    halt                = 1'b0;
    accumulator_load    = 1'b0;
    accumulator_control = 1'b0;
    memIns_en           = 1'b0;
    memDa_en            = 1'b0;
    memDa_we            = 1'b0;
  endtask

  // Rising fetch-enable pulse followed by a low cycle so the next fetch sees a new edge
  task automatic fetch(input logic [7:0] ins);
    memIns_en = 1'b1;
    ins_rdata = ins;
    step();
    memIns_en = 1'b0;
    step();
  endtask

  task automatic load_acc(input logic [7:0] val);
    accumulator_load    = 1'b1;
    accumulator_control = 1'b1;
    da_rdata            = val;
    step();
    accumulator_load    = 1'b0;
    accumulator_control = 1'b0;
  endtask

  task automatic branch();
    pc_load = 1'b1;
    pc_en   = 1'b1;
    step();
    pc_load = 1'b0;
    pc_en   = 1'b0;
  endtask

  initial begin
    idle();
    ins_rdata = 8'h00;
    da_rdata  = 8'h00;
    rst       = 1'b0;
    // Strobes active during reset must have no effect
    pc_en = 1'b1; accumulator_load = 1'b1; accumulator_control = 1'b1;
    halt = 1'b1; memIns_en = 1'b1; ins_rdata = 8'hA3; da_rdata = 8'h5A;
    step();
    step();
    chk("reset_pc", 32'(ins_addr), 32'd0);
    chk("reset_acc", 32'(acc), 32'h00);
    chk("reset_zero", 32'(zero), 32'd1);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_opcode", 32'(opcode), 32'd0);

    idle();
    rst = 1'b1;
    step();
    chk("idle_pc", 32'(ins_addr), 32'd0);

    // Fetch LDA 3
    memIns_en = 1'b1; ins_rdata = 8'hA3;
    step();
    chk("fetch_opcode", 32'(opcode), 32'd5);
    chk("fetch_da_addr", 32'(da_addr), 32'd3);
    memIns_en = 1'b0;
    step();

    load_acc(8'h7F);
    chk("lda_acc", 32'(acc), 32'h7F);
    chk("lda_zero", 32'(zero), 32'd0);

    // ADD with carry out
    fetch(8'h43);
    chk("add_opcode", 32'(opcode), 32'd2);
    accumulator_load = 1'b1; da_rdata = 8'h81;
    step();
    accumulator_load = 1'b0;
    chk("add_acc", 32'(acc), 32'h00);
    chk("add_zero", 32'(zero), 32'd1);

    fetch(8'h80);
    accumulator_load = 1'b1; da_rdata = 8'h3C;
    step();
    accumulator_load = 1'b0;
    chk("xor_acc", 32'(acc), 32'h3C);

    fetch(8'h60);
    accumulator_load = 1'b1; da_rdata = 8'h0F;
    step();
    accumulator_load = 1'b0;
    chk("and_acc", 32'(acc), 32'h0C);

    // SKZ taken at pc=4
    fetch(8'hE4);
    branch();
    chk("jmp4_pc", 32'(ins_addr), 32'd4);
    load_acc(8'h00);
    fetch(8'h20);
    branch();
    chk("skz_taken_pc", 32'(ins_addr), 32'd6);

    // SKZ not taken at pc=4
    fetch(8'hE4);
    branch();
    load_acc(8'h01);
    fetch(8'h20);
    branch();
    chk("skz_not_taken_pc", 32'(ins_addr), 32'd5);

    // SKZ taken at pc=31 wraps to 1
    fetch(8'hFF);
    branch();
    chk("jmp31_pc", 32'(ins_addr), 32'd31);
    load_acc(8'h00);
    fetch(8'h20);
    branch();
    chk("skz_wrap_pc", 32'(ins_addr), 32'd1);

    fetch(8'hF4);
    branch();
    chk("jmp20_pc", 32'(ins_addr), 32'd20);
    fetch(8'h43);
    branch();
    chk("nonbranch_pc", 32'(ins_addr), 32'd21);

    // STO 9
    fetch(8'hC9);
    load_acc(8'h55);
    memDa_en = 1'b1; memDa_we = 1'b1;
    #1;
    chk("sto_da_addr", 32'(da_addr), 32'd9);
    chk("sto_da_we", 32'(da_we), 32'd1);
    chk("sto_da_en", 32'(da_en), 32'd1);
    chk("sto_da_wdata", 32'(da_wdata), 32'h55);
    memDa_en = 1'b0; memDa_we = 1'b0;

    // Halt together with an accumulator write: the write still lands
    halt = 1'b1; accumulator_load = 1'b1; accumulator_control = 1'b1; da_rdata = 8'h66;
    step();
    idle();
    chk("halt_set", 32'(halted), 32'd1);
    chk("halt_same_cycle_acc", 32'(acc), 32'h66);

    pc_en = 1'b1; accumulator_load = 1'b1; accumulator_control = 1'b1;
    da_rdata = 8'h11; memDa_en = 1'b1; memDa_we = 1'b1;
    memIns_en = 1'b1; ins_rdata = 8'h00;
    step();
    chk("halted_pc", 32'(ins_addr), 32'd21);
    chk("halted_acc", 32'(acc), 32'h66);
    chk("halted_ir", 32'(opcode), 32'd6);
    chk("halted_da_we", 32'(da_we), 32'd0);
    chk("halted_sticky", 32'(halted), 32'd1);

    // Asynchronous reset mid-instruction
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_halted", 32'(halted), 32'd0);
    chk("async_rst_acc", 32'(acc), 32'h00);
    chk("async_rst_pc", 32'(ins_addr), 32'd0);
    chk("async_rst_zero", 32'(zero), 32'd1);
    step();
    idle();
    rst = 1'b1;
    step();

    // Fetch enable held high: only the first cycle's instruction is captured
    memIns_en = 1'b1; ins_rdata = 8'hA3;
    step();
    ins_rdata = 8'h43;
    step();
    ins_rdata = 8'h20;
    step();
    chk("fetch_edge_opcode", 32'(opcode), 32'd5);
    chk("fetch_edge_operand", 32'(da_addr), 32'd3);
    memIns_en = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Datapath responder to the CPU CONTROL sequencer: consumes its strobes (pc_load, pc_en, halt, accumulator_load, accumulator_control, memIns_en, memDa_en, memDa_we) and returns the opcode that drives CONTROL.
- Owns the program counter, instruction register, accumulator, zero flag and halted latch.
- Drives the instruction-memory and data-memory ports.
- Sits between CONTROL and the two synchronous memories inside the CPU top.

Parameters:
- DW, 8, accumulator and data-memory word width.
- AW, 5, program/data address width; PC width.
- IW, 8, instruction width; opcode = ir[IW-1:IW-3], operand = ir[AW-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- pc_load  in  1  from CONTROL: branch/skip evaluate.
- pc_en  in  1  from CONTROL: PC advance.
- halt  in  1  from CONTROL: halt request.
- accumulator_load  in  1  from CONTROL: accumulator write.
- accumulator_control  in  1  from CONTROL: 1 = load from memory, 0 = ALU result.
- memIns_en  in  1  from CONTROL: instruction-fetch enable.
- memDa_en  in  1  from CONTROL: data-memory enable.
- memDa_we  in  1  from CONTROL: data-memory write.
- opcode  out  3  to CONTROL, equal to ir[IW-1:IW-3].
- ins_addr  out  AW  instruction-memory address, equal to pc.
- ins_rdata  in  IW  instruction-memory read data, one cycle after ins_addr.
- da_addr  out  AW  data-memory address, equal to ir[AW-1:0].
- da_en  out  1  equal to memDa_en.
- da_we  out  1  memDa_we AND NOT halted.
- da_wdata  out  DW  equal to acc.
- da_rdata  in  DW  data-memory read data.
- acc  out  DW  accumulator.
- zero  out  1  registered flag, 1 when acc == 0.
- halted  out  1  sticky halt status.

Behaviour:
- Reset (rst low, asynchronous): pc=0, ir=0, acc=0, zero=1, halted=0, fetch-edge register=0.
  - All registers held while rst is low; the first update occurs on the first rising clk edge after rst goes high.
  - Reset asserted mid-instruction aborts it immediately; no partial write survives.
- Opcode map (shared package): 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
- IR capture:
  - Register memIns_en as ins_en_q.
  - ir <= ins_rdata in the cycle where memIns_en=1 and ins_en_q=0 (rising edge of fetch enable) only.
  - IR holds otherwise, including while memIns_en stays high.
- Accumulator (when accumulator_load=1 and halted=0):
  - accumulator_control=1: acc <= da_rdata.
  - Otherwise ALU by opcode: ADD = acc+da_rdata modulo 2^DW, carry discarded; AND = bitwise and; XOR = bitwise xor; all others leave acc unchanged.
  - zero updates in the same cycle from the new acc value.
- PC update (halted=0), priority order:
  1. pc_load=1 and opcode=JMP: pc <= operand.
  2. pc_load=1 and opcode=SKZ: pc <= pc + (zero ? 2 : 1).
  3. pc_en=1, including pc_load=1 with any other opcode: pc <= pc+1.
  4. Otherwise hold.
  - All PC arithmetic wraps modulo 2^AW; pc=31 with SKZ taken gives 1.
- Halt:
  - halt=1 sets halted on the next edge; it clears only on reset.
  - While halted: pc, ir and acc frozen, and da_we forced to 0.
  - A halt in the same cycle as accumulator_load still allows that accumulator write; halted blocks only subsequent cycles.
- Latency: every register updates one clock after its qualifying strobe; opcode, ins_addr and da_addr are combinational from registers.
- After reset ir=0, so opcode=HLT; CONTROL only samples opcode in execute, which is after the first IR capture.

Decomposition:
- cpu_pkg: opcode_e enum (HLT..JMP), default widths DW, AW, IW, and the instruction field-position constants.
- Sub-module cpu_alu: purely combinational; inputs opcode, acc, da_rdata; output result. cpu_datapath instantiates it once.

Test Plan:
- Reset then fetch: rst low for 2 cycles with strobes mid-operation -> pc=0, acc=0, zero=1, halted=0. Raise memIns_en with ins_rdata=8'hA3 (LDA 3) -> ir=8'hA3 next edge and opcode=5.
- LDA/ADD: LDA with da_rdata=8'h7F -> acc=8'h7F, zero=0. ADD with da_rdata=8'h81 -> acc=8'h00 (carry discarded), zero=1.
- SKZ: pc=4, zero=1, opcode=SKZ, pc_load=pc_en=1 -> pc=6. Repeat with zero=0 -> pc=5. Repeat at pc=31 with zero=1 -> pc=1.
- JMP: ir=8'hF4 with pc_load=pc_en=1 -> pc=20. Non-branch opcode with pc_load=1 -> pc+1.
- STO/halt: STO at operand 9 with acc=8'h55 -> da_addr=9, da_we=1, da_wdata=8'h55. Assert halt -> halted=1; later pc_en, accumulator_load and memDa_we produce no pc/acc change and da_we=0 until rst is asserted.
- Fetch-edge: hold memIns_en high for 3 cycles while ins_rdata changes -> ir takes only the first-cycle value.
